// File: rtl/mem_responder.sv
// mem_responder: fixed-latency, byte-strobed word RAM on the native memory bus.
// Define MEM_RESPONDER_FAULT_EN to flag and block out-of-range accesses.
module mem_responder #(
  parameter int    DEPTH_WORDS = 1024,
  parameter int    LATENCY     = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        fault
);

  localparam int IW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [3:0]    cnt;
  logic [3:0]    cnt_nx;
  logic          accept;

  logic [IW-1:0] idx_q;
  logic [IW-1:0] idx_sel;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;
  logic          oor_in;
  logic          oor_q;
  logic          oor_sel;
  logic          unused_ok;

  logic [31:0]   ram [DEPTH_WORDS];

`ifdef MEM_RESPONDER_FAULT_EN
  assign oor_in    = |mem_addr[31:IW+2];
  assign unused_ok = ^{mem_instr, mem_addr[1:0]};
`else
  assign oor_in    = 1'b0;
  assign unused_ok = ^{mem_instr, mem_addr[1:0], mem_addr[31:IW+2]};
`endif

  // LATENCY==1 enters RESP on the accept edge, so use live inputs then
  assign idx_sel = (state == IDLE) ? mem_addr[IW+1:2] : idx_q;
  assign oor_sel = (state == IDLE) ? oor_in : oor_q;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_valid) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_nx = RESP;
          end else begin
            state_nx = WAIT;
            cnt_nx   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        cnt_nx = cnt - 4'd1;
        if (cnt_nx == 4'd0) state_nx = RESP;
      end
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      mem_ready <= 1'b0;
      mem_rdata <= 32'h0;
      fault     <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      mem_ready <= (state_nx == RESP);
      fault     <= (state_nx == RESP) && oor_sel;
      if (state_nx == RESP) begin
        mem_rdata <= oor_sel ? 32'h0 : ram[idx_sel];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q   <= mem_addr[IW+1:2];
      wdata_q <= mem_wdata;
      wstrb_q <= mem_wstrb;
      oor_q   <= oor_in;
    end
  end

  // write lands on the edge leaving RESP, after the old word was returned
  always_ff @(posedge clk) begin
    if (state == RESP && !oor_q && !reset) begin
      for (int k = 0; k < 4; k++) begin
        if (wstrb_q[k]) ram[idx_q][8*k +: 8] <= wdata_q[8*k +: 8];
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && state == WAIT && !mem_valid)
      $error("mem_responder: mem_valid dropped before mem_ready");
  end
`endif

endmodule
